pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/cpu_pkg.sv | 13 +
 rtl/load_use_det.sv | 23 ++
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline-control types for the CPU core.
// Holds the hazard FSM state encoding and the default register-address width.
package cpu_pkg;

  localparam int REG_AW_DEF = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH2 = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/load_use_det.sv
// Load-use hazard comparator: the decode instruction reads a register
// that the load currently in EX has not yet written back.
module load_use_det #(
  parameter int REG_AW = 4
) (
  input  logic              ex_is_load,
  input  logic              id_valid,
  input  logic              id_rd_use,
  input  logic              id_rs_use,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);

  logic w_rd_hit;
  logic w_rs_hit;

  assign w_rd_hit = id_rd_use & (id_rd == ex_rd);
  assign w_rs_hit = id_rs_use & (id_rs == ex_rd);
  assign load_use = ex_is_load & id_valid & (w_rd_hit | w_rs_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / flow controller.
// Drives PC and IF/ID enables, flush and bubble for halt, taken branch,
// jump and load-use stall. Optional perf counters are built only when
// PIPE_CTRL_PERF_EN is defined; otherwise the counter ports read 0.
//
// state  | meaning
// RUN    | normal flow, events handled combinationally
// FLUSH2 | second slot after a taken branch, ID/EX still bubbled
// HALTED | core stopped, waiting for resume
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_rd_use,
  input  logic              id_rs_use,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              br_taken,
  input  logic              id_jump,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  pipe_state_t r_state;
  pipe_state_t w_nxt;
  logic        w_load_use;
  logic        w_pc_we, w_if_id_we, w_flush, w_bubble, w_halted;

  load_use_det #(.REG_AW(REG_AW)) u_lud (
    .ex_is_load (ex_is_load),
    .id_valid   (id_valid),
    .id_rd_use  (id_rd_use),
    .id_rs_use  (id_rs_use),
    .id_rd      (id_rd),
    .id_rs      (id_rs),
    .ex_rd      (ex_rd),
    .load_use   (w_load_use)
  );

  // Output decode and next state; reset forces the safe "bubble, hold" pattern.
  always_comb begin
    w_nxt      = r_state;
    w_pc_we    = 1'b0;
    w_if_id_we = 1'b0;
    w_flush    = 1'b0;
    w_bubble   = 1'b1;
    w_halted   = 1'b0;
    if (!rst) begin
      w_nxt = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (halt_req) begin
            w_flush = 1'b1;
            w_nxt   = HALTED;
          end else if (br_taken) begin
            w_pc_we    = 1'b1;
            w_if_id_we = 1'b1;
            w_flush    = 1'b1;
            w_nxt      = FLUSH2;
          end else if (id_jump) begin
            w_pc_we    = 1'b1;
            w_if_id_we = 1'b1;
            w_flush    = 1'b1;
            w_bubble   = 1'b0;
          end else if (w_load_use) begin
            w_bubble = 1'b1;
          end else begin
            w_pc_we    = 1'b1;
            w_if_id_we = 1'b1;
            w_bubble   = 1'b0;
          end
        end
        FLUSH2: begin
          // A halt arriving here still wins; a second branch cannot be real.
          if (halt_req) begin
            w_flush = 1'b1;
            w_nxt   = HALTED;
          end else begin
            w_pc_we    = 1'b1;
            w_if_id_we = 1'b1;
            w_nxt      = RUN;
          end
        end
        HALTED: begin
          w_halted = 1'b1;
          if (resume) w_nxt = RUN;
        end
        default: w_nxt = RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_nxt;
  end

  assign pc_we        = w_pc_we;
  assign if_id_we     = w_if_id_we;
  assign if_id_flush  = w_flush;
  assign id_ex_bubble = w_bubble;
  assign halted       = w_halted;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;

  // Saturating perf counters for stalled and flushed cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (!w_pc_we && (r_stall != {CNT_W{1'b1}})) r_stall <= r_stall + 1'b1;
      if (w_flush  && (r_flush != {CNT_W{1'b1}})) r_flush <= r_flush + 1'b1;
    end
  end

  assign stall_cycles = r_stall;
  assign flush_count  = r_flush;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a reference model predicts each cycle's outputs,
// pushes them to a scoreboard queue, and the sampled DUT outputs are
// popped against it. Counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  localparam int AW = 4;
  localparam int CW = 16;
  localparam logic [CW-1:0] ONES = {CW{1'b1}};

  typedef struct packed {
    logic          pc_we, if_id_we, flush, bubble, halted;
    logic [CW-1:0] stall, fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid = 0, id_rd_use = 0, id_rs_use = 0, ex_is_load = 0;
  logic [AW-1:0] id_rd = 0, id_rs = 0, ex_rd = 0;
  logic br_taken = 0, id_jump = 0, halt_req = 0, resume = 0;
  logic pc_we, if_id_we, if_id_flush, id_ex_bubble, halted;
  logic [CW-1:0] stall_cycles, flush_count;

  // staged stimulus, applied at the falling edge by cyc()
  logic s_rst = 0, s_v = 0, s_rdu = 0, s_rsu = 0, s_ld = 0;
  logic [AW-1:0] s_rd = 0, s_rs = 0, s_exrd = 0;
  logic s_br = 0, s_jmp = 0, s_hlt = 0, s_res = 0;

  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];

  int m_state = 0;  // 0 run, 1 flush2, 2 halted
  logic [CW-1:0] m_stall = 0, m_fcnt = 0;
  logic [CW-1:0] snap;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd_use(id_rd_use),
    .id_rs_use(id_rs_use), .id_rd(id_rd), .id_rs(id_rs),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .br_taken(br_taken),
    .id_jump(id_jump), .halt_req(halt_req), .resume(resume),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    s_rst = 1; s_v = 0; s_rdu = 0; s_rsu = 0; s_ld = 0; s_rd = 0; s_rs = 0;
    s_exrd = 0; s_br = 0; s_jmp = 0; s_hlt = 0; s_res = 0;
  endtask

  task automatic cyc(input bit do_chk);
    exp_t e, got;
    int nxt;
    logic lu;
    @(negedge clk);
    rst = s_rst; id_valid = s_v; id_rd_use = s_rdu; id_rs_use = s_rsu;
    id_rd = s_rd; id_rs = s_rs; ex_is_load = s_ld; ex_rd = s_exrd;
    br_taken = s_br; id_jump = s_jmp; halt_req = s_hlt; resume = s_res;
    if (!s_rst) begin
      m_state = 0; m_stall = 0; m_fcnt = 0;
    end
    lu = s_ld && s_v && ((s_rdu && (s_rd == s_exrd)) || (s_rsu && (s_rs == s_exrd)));
    e = '0;
    e.stall = m_stall; e.fcnt = m_fcnt;
    nxt = m_state;
    if (!s_rst) begin
      e.bubble = 1; nxt = 0;
    end else if (m_state == 2) begin
      e.bubble = 1; e.halted = 1;
      if (s_res) nxt = 0;
    end else if (s_hlt) begin
      e.flush = 1; e.bubble = 1; nxt = 2;
    end else if (m_state == 1) begin
      e.pc_we = 1; e.if_id_we = 1; e.bubble = 1; nxt = 0;
    end else if (s_br) begin
      e.pc_we = 1; e.if_id_we = 1; e.flush = 1; e.bubble = 1; nxt = 1;
    end else if (s_jmp) begin
      e.pc_we = 1; e.if_id_we = 1; e.flush = 1;
    end else if (lu) begin
      e.bubble = 1;
    end else begin
      e.pc_we = 1; e.if_id_we = 1;
    end
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    if (do_chk) begin
      chk("pc_we", {31'd0, pc_we}, {31'd0, got.pc_we});
      chk("if_id_we", {31'd0, if_id_we}, {31'd0, got.if_id_we});
      chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, got.flush});
      chk("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, got.bubble});
      chk("halted", {31'd0, halted}, {31'd0, got.halted});
      chk("stall_cycles", {16'd0, stall_cycles}, {16'd0, got.stall});
      chk("flush_count", {16'd0, flush_count}, {16'd0, got.fcnt});
    end
    if (s_rst) begin
      m_state = nxt;
`ifdef PIPE_CTRL_PERF_EN
      if (!e.pc_we && m_stall != ONES) m_stall = m_stall + 1'b1;
      if (e.flush && m_fcnt != ONES) m_fcnt = m_fcnt + 1'b1;
`endif
    end
  endtask

  initial begin
    idle(); s_rst = 0; s_br = 1; s_hlt = 1;
    repeat (2) cyc(1);               // reset holds, inputs ignored
    idle(); repeat (2) cyc(1);
    // load-use on rs, then normal flow
    s_v = 1; s_ld = 1; s_exrd = 3; s_rsu = 1; s_rs = 3; cyc(1);
    idle(); s_v = 1; s_rsu = 1; s_rs = 3; cyc(1);
    // load-use on rd; mismatch; invalid decode
    idle(); s_v = 1; s_ld = 1; s_exrd = 7; s_rdu = 1; s_rd = 7; cyc(1);
    idle(); s_v = 1; s_ld = 1; s_exrd = 5; s_rsu = 1; s_rs = 3; s_rdu = 1; s_rd = 4; cyc(1);
    idle(); s_v = 0; s_ld = 1; s_exrd = 3; s_rsu = 1; s_rs = 3; cyc(1);
    // taken branch, flush_count delta
    idle(); snap = flush_count; s_br = 1; cyc(1);
    idle(); repeat (2) cyc(1);
`ifdef PIPE_CTRL_PERF_EN
    chk("flush_delta", {16'd0, flush_count - snap}, 32'd1);
`else
    chk("flush_delta", {16'd0, flush_count - snap}, 32'd0);
`endif
    // branch plus load-use: branch wins
    idle(); s_br = 1; s_v = 1; s_ld = 1; s_exrd = 2; s_rsu = 1; s_rs = 2; cyc(1);
    idle(); s_br = 1; cyc(1);        // ignored in FLUSH2
    idle(); s_jmp = 1; s_v = 1; s_ld = 1; s_exrd = 1; s_rdu = 1; s_rd = 1; cyc(1);
    idle(); cyc(1);
    // halt inside FLUSH2, then resume together with halt_req
    s_br = 1; cyc(1);
    idle(); s_hlt = 1; cyc(1);
    idle(); s_br = 1; s_jmp = 1; cyc(1);
    idle(); s_res = 1; s_hlt = 1; cyc(1);
    idle(); cyc(1);
    // halt, ten stalled cycles, resume
    snap = stall_cycles; s_hlt = 1; cyc(1);
    idle(); repeat (9) cyc(1);
    s_res = 1; cyc(1);
    idle(); cyc(1);
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_delta", {16'd0, stall_cycles - snap}, 32'd11);
`else
    chk("stall_delta", {16'd0, stall_cycles - snap}, 32'd0);
`endif
    // reset mid-FLUSH2 and mid-HALTED
    s_br = 1; cyc(1);
    idle(); s_rst = 0; cyc(1);
    idle(); cyc(1); cyc(1);
    s_hlt = 1; cyc(1);
    idle(); cyc(1); s_rst = 0; cyc(1);
    idle(); cyc(1);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      idle();
      s_v = 1'($urandom_range(0, 1)); s_rdu = 1'($urandom_range(0, 1));
      s_rsu = 1'($urandom_range(0, 1)); s_ld = 1'($urandom_range(0, 1));
      s_rd = 4'($urandom_range(0, 3)); s_rs = 4'($urandom_range(0, 3));
      s_exrd = 4'($urandom_range(0, 3));
      s_br = ($urandom_range(0, 5) == 0); s_jmp = ($urandom_range(0, 5) == 0);
      s_hlt = ($urandom_range(0, 15) == 0); s_res = ($urandom_range(0, 3) == 0);
      s_rst = ($urandom_range(0, 60) != 0);
      cyc(1);
    end
    // long stall burst to reach saturation
    idle(); cyc(1); s_res = 1; cyc(1);
    idle(); s_rst = 0; cyc(1);
    idle(); s_hlt = 1; cyc(1);
    idle();
`ifdef PIPE_CTRL_PERF_EN
    for (int i = 0; i < (1 << CW) + 5; i++) cyc(0);
    cyc(1);
    chk("stall_sat", {16'd0, stall_cycles}, {16'd0, ONES});
`else
    repeat (40) cyc(0);
    cyc(1);
    chk("stall_off", {16'd0, stall_cycles}, 32'd0);
    chk("flush_off", {16'd0, flush_count}, 32'd0);
`endif
    s_res = 1; cyc(1);
    idle(); cyc(1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
